instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs per-field instruction descriptions (type, opcode, registers, immediate, memory address) into the 64-bit instruction word format used by the core's decode stage.
- Queues encoded words in a small FIFO.
- Drains the FIFO into instruction memory through a write port with an auto-incrementing address.
- Sits between the program loader/test host and instruction memory; rejects illegal encodings and counts them.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 10, instruction-memory address width
- BASE_ADDR, 0, write-address counter value after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_type  in  6  opcode type
- in_opcode  in  6  opcode
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register
- in_imm  in  16  immediate / shift amount
- in_maddr  in  16  memory/branch target address
- mem_we  out  1  write request to instruction memory
- mem_ready  in  1  memory accepts write this cycle
- mem_waddr  out  AW  write address
- mem_wdata  out  64  encoded instruction
- addr_load  in  1  load write-address counter
- addr_value  in  AW  value for addr_load
- err  out  1  one-cycle pulse: illegal bundle dropped
- err_count  out  8  illegal bundles seen, saturating
- level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Word layout:
  - [63:58] type
  - [57:52] opcode
  - [51:47] rs1
  - [46:42] rs2 or shift amount
  - [41:37] rd
  - [36:21] imm or maddr
  - [20:0] always 0
- Every field not listed for a type is forced to 0 regardless of input.
- Fields packed per type:
  - Type 0 ALU: rs1, rs2, rd.
  - Type 1 Shift: rs1, rd; in_imm[4:0] goes to [46:42]. Illegal if in_imm[15:5] != 0.
  - Type 2 Memory, opcode 1 load: rs1, rd, maddr.
  - Type 2 Memory, opcode 2 store: rs1, maddr.
  - Type 2 Memory, any other opcode: illegal.
  - Type 3 Branch, type 4 Jump: maddr only.
  - Type 5 Compare: rs1, rs2.
  - Type 6 Immediate: rd, imm at [36:21].
  - Types 7–63: illegal.
- Opcode is copied verbatim for all legal types.
- Accept: handshake in_valid && in_ready.
  - in_ready = !full (combinational from occupancy).
  - Legal accepted bundle is written into the FIFO at that edge and is visible at the head no earlier than the next cycle. There is no bypass.
- Illegal accepted bundle:
  - Not written to the FIFO.
  - err = 1 the following cycle for exactly one cycle.
  - err_count increments, saturating at 255.
- Drain:
  - mem_we = !empty (combinational).
  - mem_wdata = head entry; mem_waddr = address counter.
  - Write completes when mem_we && mem_ready. That edge pops the head and increments the counter modulo 2^AW (wraps from 2^AW-1 to 0).
  - mem_wdata and mem_waddr are held stable while mem_we && !mem_ready.
- Simultaneous push and pop: allowed whenever not full; level is unchanged. Pop is impossible when empty, so a push into an empty FIFO raises level 0→1.
- addr_load:
  - Counter ← addr_value next edge; takes priority over increment.
  - A write completing in the same cycle uses the old address.
  - FIFO contents are unaffected.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO emptied; level = 0; mem_we = 0; in_ready = 1.
  - Counter = BASE_ADDR; err = 0; err_count = 0.
  - In-flight words are discarded.
  - Outputs take reset values immediately on rst assertion, not at the next edge.

Test Plan:
- ALU encode: type=0, op=3, rs1=1, rs2=2, rd=3, imm=FFFF, maddr=FFFF with mem_ready=1 -> next cycle mem_we=1, mem_waddr=0, mem_wdata=64'h0030_8860_0000_0000 (imm/maddr zeroed).
- Load then store, mem_ready=1:
  - load (type 2, op 1, rs1=4, rd=5, maddr=1234) -> word at addr 0 = {6'd2,6'd1,5'd4,5'd0,5'd5,16'h1234,21'd0}.
  - store (type 2, op 2, rs1=4, rd=5, maddr=1234) -> word at addr 1 = {6'd2,6'd2,5'd4,5'd0,5'd0,16'h1234,21'd0}; rd ignored.
- Illegal bundles: type=7; type=2 op=3; type=1 imm=0x0020 -> three err pulses, err_count=3, no mem_we, level stays 0. Then push 255 more illegal bundles -> err_count=255.
- Backpressure: mem_ready=0, push 5 legal words -> in_ready=0 after 4th, level=4, 5th held. Raise mem_ready -> writes to addresses 0..4 in push order, data stable while stalled.
- Wrap and load: addr_load=1, addr_value=3FF, then 2 writes -> addresses 3FF, 000. addr_load in the same cycle as a write completion -> that write uses the old address, the next write uses addr_value.
- Reset mid-drain: 3 words queued, assert rst asynchronously -> mem_we=0, level=0, in_ready=1, err_count=0 immediately. After release, the first write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field bundles into 64-bit instruction words,
// queues them in a small FIFO and drains them into instruction memory.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_type,
  input  logic [5:0]               in_opcode,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [15:0]              in_maddr,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_waddr,
  output logic [63:0]              mem_wdata,
  input  logic                     addr_load,
  input  logic [AW-1:0]            addr_value,
  output logic                     err,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [AW-1:0] r_addr;
  logic          r_err;
  logic [7:0]    r_err_count;

  logic          w_legal;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [4:0]    w_rd;
  logic [15:0]   w_imm;
  logic [63:0]   w_word;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push;
  logic          w_bad;
  logic          w_pop;

  // Select which fields each type carries; unused fields stay zero.
  always_comb begin
    w_legal = 1'b1;
    w_rs1   = '0;
    w_rs2   = '0;
    w_rd    = '0;
    w_imm   = '0;
    case (in_type)
      6'd0: begin
        w_rs1 = in_rs1;
        w_rs2 = in_rs2;
        w_rd  = in_rd;
      end
      6'd1: begin
        // Shift amount shares the rs2 slot; wider amounts are rejected.
        w_rs1   = in_rs1;
        w_rd    = in_rd;
        w_rs2   = in_imm[4:0];
        w_legal = (in_imm[15:5] == 11'd0);
      end
      6'd2: begin
        case (in_opcode)
          6'd1: begin
            w_rs1 = in_rs1;
            w_rd  = in_rd;
            w_imm = in_maddr;
          end
          6'd2: begin
            w_rs1 = in_rs1;
            w_imm = in_maddr;
          end
          default: w_legal = 1'b0;
        endcase
      end
      6'd3, 6'd4: w_imm = in_maddr;
      6'd5: begin
        w_rs1 = in_rs1;
        w_rs2 = in_rs2;
      end
      6'd6: begin
        w_rd  = in_rd;
        w_imm = in_imm;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_word   = {in_type, in_opcode, w_rs1, w_rs2, w_rd, w_imm, 21'd0};

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_accept = in_valid && !w_full;
  assign w_push   = w_accept && w_legal;
  assign w_bad    = w_accept && !w_legal;
  assign w_pop    = !w_empty && mem_ready;

  // FIFO storage; contents are don't-care when not counted by r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Write-address counter; an explicit load wins over the post-write increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= AW'(BASE_ADDR);
    end else if (addr_load) begin
      r_addr <= addr_value;
    end else if (w_pop) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  // Illegal-bundle pulse and saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_bad;
      if (w_bad && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign in_ready  = !w_full;
  assign mem_we    = !w_empty;
  assign mem_waddr = r_addr;
  assign mem_wdata = r_mem[r_rptr];
  assign err       = r_err;
  assign err_count = r_err_count;
  assign level     = r_level;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a
// negedge monitor pops and compares every completed memory write.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned BASE  = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_type = '0;
  logic [5:0]    in_opcode = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [4:0]    in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic [15:0]   in_maddr = '0;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_waddr;
  logic [63:0]   mem_wdata;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_value = '0;
  logic          err;
  logic [7:0]    err_count;
  logic [2:0]    level;

  int            total = 0;
  int            bad = 0;
  int            illegal_n = 0;
  logic          rr_en = 1'b0;
  logic [63:0]   exp_q [$];
  logic [AW-1:0] log_a [$];
  logic [63:0]   log_d [$];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_maddr  (in_maddr),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .addr_load (addr_load),
    .addr_value(addr_value),
    .err       (err),
    .err_count (err_count),
    .level     (level)
  );

  // Reference encoding: {legal, word} built from bit positions by arithmetic.
  function automatic logic [64:0] ref_enc(input logic [5:0] t, input logic [5:0] op,
                                          input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] d, input logic [15:0] im,
                                          input logic [15:0] ma);
    logic        legal;
    logic [63:0] fa, fb, fd, fm, w;
    legal = 1'b1;
    fa = 64'd0;
    fb = 64'd0;
    fd = 64'd0;
    fm = 64'd0;
    if (t == 6'd0) begin
      fa = 64'(a); fb = 64'(b); fd = 64'(d);
    end else if (t == 6'd1) begin
      fa = 64'(a); fd = 64'(d); fb = 64'(im) % 64'd32;
      legal = (im < 16'd32);
    end else if (t == 6'd2 && op == 6'd1) begin
      fa = 64'(a); fd = 64'(d); fm = 64'(ma);
    end else if (t == 6'd2 && op == 6'd2) begin
      fa = 64'(a); fm = 64'(ma);
    end else if (t == 6'd3 || t == 6'd4) begin
      fm = 64'(ma);
    end else if (t == 6'd5) begin
      fa = 64'(a); fb = 64'(b);
    end else if (t == 6'd6) begin
      fd = 64'(d); fm = 64'(im);
    end else begin
      legal = 1'b0;
    end
    w = (64'(t) << 58) + (64'(op) << 52) + (fa << 47) + (fb << 42) + (fd << 37) + (fm << 21);
    return {legal, w};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: err pulse timing, stall stability, and write-order scoreboard.
  initial begin
    logic [AW-1:0] m_addr;
    logic          exp_err;
    logic          p_stall;
    logic [AW-1:0] p_a;
    logic [63:0]   p_d;
    logic [64:0]   r;
    logic [63:0]   e;
    m_addr  = AW'(BASE);
    exp_err = 1'b0;
    p_stall = 1'b0;
    p_a     = '0;
    p_d     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_addr  = AW'(BASE);
        exp_err = 1'b0;
        p_stall = 1'b0;
      end else begin
        if (exp_err || err) chk("err_pulse", 64'(err), 64'(exp_err));
        r = ref_enc(in_type, in_opcode, in_rs1, in_rs2, in_rd, in_imm, in_maddr);
        exp_err = in_valid && in_ready && !r[64];
        if (p_stall) begin
          chk("stall_we", 64'(mem_we), 64'd1);
          chk("stall_addr", 64'(mem_waddr), 64'(p_a));
          chk("stall_data", mem_wdata, p_d);
        end
        if (mem_we && exp_q.size() == 0) fail_now("mem_we_without_queued_word");
        if (mem_we && mem_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wdata", mem_wdata, e);
          chk("waddr", 64'(mem_waddr), 64'(m_addr));
          log_a.push_back(mem_waddr);
          log_d.push_back(mem_wdata);
        end
        p_stall = mem_we && !mem_ready && !addr_load;
        p_a = mem_waddr;
        p_d = mem_wdata;
        if (addr_load) m_addr = addr_value;
        else if (mem_we && mem_ready) m_addr = m_addr + AW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_en) begin
      mem_ready  = ($urandom_range(0, 1) == 1);
      addr_load  = ($urandom_range(0, 15) == 0);
      addr_value = AW'($urandom);
    end
  endtask

  task automatic drive(input logic [5:0] t, input logic [5:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic [15:0] im,
                       input logic [15:0] ma);
    in_type = t; in_opcode = op; in_rs1 = a; in_rs2 = b; in_rd = d;
    in_imm = im; in_maddr = ma;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic [64:0] r;
    bit ok;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        r = ref_enc(in_type, in_opcode, in_rs1, in_rs2, in_rd, in_imm, in_maddr);
        if (r[64]) exp_q.push_back(r[63:0]);
        else illegal_n++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic send(input logic [5:0] t, input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [15:0] im,
                      input logic [15:0] ma);
    drive(t, op, a, b, d, im, ma);
    wait_accept();
  endtask

  task automatic send_rand_legal();
    send(6'($urandom_range(3, 6)), 6'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    rr_en = 1'b0;
    addr_load = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) fail_now("drain_timeout");
    chk("drain_level", 64'(level), 64'd0);
  endtask

  task automatic set_addr(input logic [AW-1:0] v);
    addr_load = 1'b1;
    addr_value = v;
    tick();
    addr_load = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  initial begin
    logic [5:0] t;
    #2;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_addr", 64'(mem_waddr), 64'(BASE));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ALU: imm/maddr must be zeroed; word visible one cycle after accept.
    mem_ready = 1'b1;
    send(6'd0, 6'd3, 5'd1, 5'd2, 5'd3, 16'hFFFF, 16'hFFFF);
    chk("alu_we", 64'(mem_we), 64'd1);
    chk("alu_addr", 64'(mem_waddr), 64'd0);
    chk("alu_data", mem_wdata, 64'h0030_8860_0000_0000);
    drain();

    // Load then store; store drops rd.
    set_addr('0);
    clear_log();
    send(6'd2, 6'd1, 5'd4, 5'd0, 5'd5, 16'h0, 16'h1234);
    send(6'd2, 6'd2, 5'd4, 5'd0, 5'd5, 16'h0, 16'h1234);
    drain();
    chk("ls_count", 64'(log_d.size()), 64'd2);
    if (log_d.size() >= 2) begin
      chk("ld_addr", 64'(log_a[0]), 64'd0);
      chk("ld_data", log_d[0], {6'd2, 6'd1, 5'd4, 5'd0, 5'd5, 16'h1234, 21'd0});
      chk("st_addr", 64'(log_a[1]), 64'd1);
      chk("st_data", log_d[1], {6'd2, 6'd2, 5'd4, 5'd0, 5'd0, 16'h1234, 21'd0});
    end

    // Illegal bundles.
    send(6'd7, 6'd0, 5'd1, 5'd1, 5'd1, 16'h0, 16'h0);
    send(6'd2, 6'd3, 5'd1, 5'd1, 5'd1, 16'h0, 16'h0);
    send(6'd1, 6'd0, 5'd1, 5'd1, 5'd1, 16'h0020, 16'h0);
    tick();
    tick();
    chk("ill_errcnt", 64'(err_count), 64'd3);
    chk("ill_level", 64'(level), 64'd0);
    for (int i = 0; i < 255; i++) begin
      send(6'($urandom_range(7, 63)), 6'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), 16'($urandom));
    end
    chk("ill_sat", 64'(err_count), 64'd255);
    chk("ill_sat_n", 64'(illegal_n), 64'd258);

    // Backpressure: four fill the FIFO, fifth is held.
    set_addr('0);
    clear_log();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand_legal();
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_ready", 64'(in_ready), 64'd0);
    drive(6'd5, 6'd9, 5'd7, 5'd8, 5'd9, 16'h0, 16'h0);
    tick();
    tick();
    chk("bp_held_level", 64'(level), 64'd4);
    chk("bp_no_write", 64'(log_a.size()), 64'd0);
    mem_ready = 1'b1;
    wait_accept();
    drain();
    chk("bp_count", 64'(log_a.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) chk("bp_addr", 64'(log_a[i]), 64'(i));

    // Address wrap.
    set_addr(10'h3FF);
    clear_log();
    send_rand_legal();
    send_rand_legal();
    drain();
    chk("wrap_count", 64'(log_a.size()), 64'd2);
    if (log_a.size() >= 2) begin
      chk("wrap_a0", 64'(log_a[0]), 64'h3FF);
      chk("wrap_a1", 64'(log_a[1]), 64'h000);
    end

    // addr_load together with a completing write.
    clear_log();
    mem_ready = 1'b0;
    send_rand_legal();
    send_rand_legal();
    mem_ready = 1'b1;
    addr_load = 1'b1;
    addr_value = 10'h100;
    tick();
    addr_load = 1'b0;
    drain();
    chk("ldw_count", 64'(log_a.size()), 64'd2);
    if (log_a.size() >= 2) begin
      chk("ldw_old", 64'(log_a[0]), 64'h001);
      chk("ldw_new", 64'(log_a[1]), 64'h100);
    end

    // Randomized traffic with random backpressure and address loads.
    rr_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      t = 6'($urandom_range(0, 8));
      send(t, (t == 6'd2) ? 6'($urandom_range(0, 3)) : 6'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom),
           ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom),
           16'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    chk("rand_errcnt", 64'(err_count), (illegal_n > 255) ? 64'd255 : 64'(illegal_n));

    // Asynchronous reset in the middle of a stalled drain.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand_legal();
    chk("mid_level", 64'(level), 64'd3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_we", 64'(mem_we), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_errcnt", 64'(err_count), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    clear_log();
    mem_ready = 1'b1;
    send_rand_legal();
    drain();
    chk("post_rst_count", 64'(log_a.size()), 64'd1);
    if (log_a.size() >= 1) chk("post_rst_addr", 64'(log_a[0]), 64'(BASE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
